// File: rtl/wb_pmem_responder.sv
// wb_pmem_responder: Wishbone pmem slave with fixed-latency line-granular backing store
module wb_pmem_responder #(
    parameter int ADR_WIDTH  = 12,
    parameter int DEPTH_LOG2 = 9,
    parameter int LATENCY    = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CYC,
    input  logic                 STB,
    input  logic                 WE,
    input  logic [15:0]          SEL,
    input  logic [ADR_WIDTH-1:0] ADR,
    input  logic [127:0]         DAT_M,
    output logic [127:0]         DAT_S,
    output logic                 ACK,
    output logic                 RTY
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP, TURN} state_t;
    state_t state, state_d;
    logic [3:0] cnt, cnt_d;
    logic cap_we;
    logic [15:0] cap_sel;
    logic [ADR_WIDTH-1:0] cap_adr;
    logic [127:0] cap_dat;
    logic [127:0] mem [2**DEPTH_LOG2];
    logic go_resp, in_range, eff_we;
    logic [15:0] eff_sel;
    logic [ADR_WIDTH-1:0] eff_adr;
    logic [127:0] eff_dat;
    logic [DEPTH_LOG2-1:0] idx;
    // With LATENCY=1 the response fires on the accept edge, so the live bus is used then
    assign eff_we   = (state == IDLE) ? WE : cap_we;
    assign eff_sel  = (state == IDLE) ? SEL : cap_sel;
    assign eff_adr  = (state == IDLE) ? ADR : cap_adr;
    assign eff_dat  = (state == IDLE) ? DAT_M : cap_dat;
    assign idx      = eff_adr[DEPTH_LOG2-1:0];
    assign in_range = (eff_adr >> DEPTH_LOG2) == '0;
    // Next-state and latency countdown; go_resp marks the edge that enters RESP
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        go_resp = 1'b0;
        case (state)
            IDLE: if (CYC && STB) begin
                cnt_d   = 4'(LATENCY - 1);
                go_resp = (LATENCY == 1);
                state_d = go_resp ? RESP : BUSY;
            end
            BUSY: if (!CYC) state_d = IDLE;
            else begin
                cnt_d   = cnt - 4'd1;
                go_resp = (cnt <= 4'd1);
                state_d = go_resp ? RESP : BUSY;
            end
            RESP: state_d = TURN;
            TURN: state_d = IDLE;
        endcase
    end
    // State, captured request and registered termination outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            cnt     <= '0;
            ACK     <= 1'b0;
            RTY     <= 1'b0;
            DAT_S   <= '0;
            cap_we  <= 1'b0;
            cap_sel <= '0;
            cap_adr <= '0;
            cap_dat <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            ACK   <= go_resp && in_range;
            RTY   <= go_resp && !in_range;
            if (state == IDLE && CYC && STB) begin
                cap_we  <= WE;
                cap_sel <= SEL;
                cap_adr <= ADR;
                cap_dat <= DAT_M;
            end
            if (go_resp) DAT_S <= (in_range && !eff_we) ? mem[idx] : '0;
        end
    end
    // Byte-enabled line write, committed on the edge that enters RESP
    always_ff @(posedge CLK) begin
        if (RST_N && go_resp && in_range && eff_we)
            for (int i = 0; i < 16; i++)
                if (eff_sel[i]) mem[idx][8*i +: 8] <= eff_dat[8*i +: 8];
    end
endmodule
